// File: rtl/time_set_ctrl.sv
// time_set_ctrl: mode/adjust button sequencer for setting an HH:MM:SS clock.
// Define TIME_SET_AUTO_REPEAT_EN to add auto-repeat on a held adjust button.
module time_set_ctrl #(
  parameter int HOLD_MS    = 500,
  parameter int REPEAT_MS  = 200,
  parameter int TIMEOUT_MS = 10000,
  parameter int BLINK_MS   = 250
) (
  input  logic       CP_1KHz,
  input  logic       nCR,
  input  logic       btn_mode,
  input  logic       btn_adj,
  output logic [1:0] sel,
  output logic       run_en,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       blink
);
  // state   | meaning
  // RUN     | time counters running, nothing selected
  // SET_HR  | adj increments hours
  // SET_MIN | adj increments minutes
  // SET_SEC | adj clears seconds
  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_t;

  localparam int M1 = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int M2 = (TIMEOUT_MS > BLINK_MS) ? TIMEOUT_MS : BLINK_MS;
  localparam int M3 = (M1 > M2) ? M1 : M2;
  localparam int CW = ($clog2(M3) > 14) ? $clog2(M3) : 14;
  localparam logic [CW-1:0] IDLE_LD  = CW'(TIMEOUT_MS - 1);
  localparam logic [CW-1:0] BLINK_LD = CW'(BLINK_MS - 1);

  state_t        state_q, state_d;
  logic          mode_q, mode_d, mode_prev_q, mode_prev_d, mode_arm_q, mode_arm_d;
  logic          adj_q, adj_d, adj_prev_q, adj_prev_d, adj_arm_q, adj_arm_d;
  logic [CW-1:0] idle_q, idle_d, blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic          inc_hr_q, inc_hr_d, inc_min_q, inc_min_d, clr_sec_q, clr_sec_d;
  logic          blink_q, blink_d, run_en_q, run_en_d;
  logic          mode_press, adj_press, adj_ok, state_chg, rpt_fire, pulse;

  // The arm flags block a button held through reset from reading as a press.
  always_comb begin
    mode_d      = btn_mode;
    mode_prev_d = mode_q;
    mode_arm_d  = mode_arm_q | ~btn_mode;
    adj_d       = btn_adj;
    adj_prev_d  = adj_q;
    adj_arm_d   = adj_arm_q | ~btn_adj;
    mode_press  = mode_q & ~mode_prev_q & mode_arm_q;
    adj_press   = adj_q & ~adj_prev_q & adj_arm_q;
    adj_ok      = adj_press & ~mode_press & (state_q != RUN);
    state_d     = state_q;
    if (mode_press) begin
      case (state_q)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        default: state_d = RUN;
      endcase
    end else if ((state_q != RUN) && (idle_q == '0)) begin
      state_d = RUN;
    end
    state_chg = (state_d != state_q);
  end

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_MS - 1);
  localparam logic [CW-1:0] RPT_LD  = CW'(REPEAT_MS - 1);
  logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_act_q, rpt_act_d, rpt_state;

  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_act_d = rpt_act_q;
    rpt_fire  = 1'b0;
    rpt_state = (state_q == SET_HR) || (state_q == SET_MIN);
    if (mode_press || state_chg || !adj_q || !rpt_state) begin
      rpt_act_d = 1'b0;
      rpt_cnt_d = '0;
    end else if (adj_ok) begin
      rpt_act_d = 1'b1;
      rpt_cnt_d = HOLD_LD;
    end else if (rpt_act_q) begin
      if (rpt_cnt_q == '0) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = RPT_LD;
      end else begin
        rpt_cnt_d = rpt_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CP_1KHz or negedge nCR) begin
    if (!nCR) begin
      rpt_cnt_q <= '0;
      rpt_act_q <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_act_q <= rpt_act_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    idle_d = idle_q;
    if (state_chg || mode_press || adj_press || adj_q || (state_q == RUN)) idle_d = IDLE_LD;
    else if (idle_q != '0) idle_d = idle_q - CW'(1);
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (state_chg || (state_q == RUN)) begin
      blink_cnt_d = BLINK_LD;
      blink_ph_d  = 1'b0;
    end else if (blink_cnt_q == '0) begin
      blink_cnt_d = BLINK_LD;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q - CW'(1);
    end
    pulse     = adj_ok | rpt_fire;
    inc_hr_d  = pulse & (state_q == SET_HR);
    inc_min_d = pulse & (state_q == SET_MIN);
    clr_sec_d = adj_ok & (state_q == SET_SEC);
    blink_d   = (state_d != RUN) & blink_ph_d & ~pulse;
    run_en_d  = (state_d == RUN);
  end

  always_ff @(posedge CP_1KHz or negedge nCR) begin
    if (!nCR) begin
      state_q     <= RUN;
      mode_q      <= 1'b0;
      mode_prev_q <= 1'b0;
      mode_arm_q  <= 1'b0;
      adj_q       <= 1'b0;
      adj_prev_q  <= 1'b0;
      adj_arm_q   <= 1'b0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      inc_hr_q    <= 1'b0;
      inc_min_q   <= 1'b0;
      clr_sec_q   <= 1'b0;
      blink_q     <= 1'b0;
      run_en_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      mode_prev_q <= mode_prev_d;
      mode_arm_q  <= mode_arm_d;
      adj_q       <= adj_d;
      adj_prev_q  <= adj_prev_d;
      adj_arm_q   <= adj_arm_d;
      idle_q      <= idle_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      inc_hr_q    <= inc_hr_d;
      inc_min_q   <= inc_min_d;
      clr_sec_q   <= clr_sec_d;
      blink_q     <= blink_d;
      run_en_q    <= run_en_d;
    end
  end

  assign sel     = state_q;
  assign run_en  = run_en_q;
  assign inc_hr  = inc_hr_q;
  assign inc_min = inc_min_q;
  assign clr_sec = clr_sec_q;
  assign blink   = blink_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed scenarios plus random button traffic for time_set_ctrl,
// checked against a cycle-count reference model of the button/timeout/blink rules.
module tb_time_set_ctrl;
  localparam int HOLD = 500;
  localparam int RPT  = 200;
  localparam int TO   = 10000;
  localparam int BL   = 250;
`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nCR = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_adj = 1'b0;
  logic [1:0] sel;
  logic       run_en, inc_hr, inc_min, clr_sec, blink;
  logic [6:0] dut_vec;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(.HOLD_MS(HOLD), .REPEAT_MS(RPT), .TIMEOUT_MS(TO), .BLINK_MS(BL)) dut (
    .CP_1KHz(clk), .nCR(nCR), .btn_mode(btn_mode), .btn_adj(btn_adj),
    .sel(sel), .run_en(run_en), .inc_hr(inc_hr), .inc_min(inc_min),
    .clr_sec(clr_sec), .blink(blink)
  );

  assign dut_vec = {sel, run_en, inc_hr, inc_min, clr_sec, blink};

  // Reference model: state index, elapsed-cycle counts and press bookkeeping.
  int m_st, m_idle, m_since, m_hold_start, m_cyc, m_fire;
  bit m_rpt_on, m_pend_m, m_pend_a, m_samp_a, m_prev_m, m_prev_a, m_arm_m, m_arm_a, m_blink;

  task automatic model_reset();
    m_st = 0; m_idle = 0; m_since = 0; m_hold_start = 0; m_fire = 0;
    m_rpt_on = 0; m_pend_m = 0; m_pend_a = 0; m_samp_a = 0;
    m_prev_m = 0; m_prev_a = 0; m_arm_m = 0; m_arm_a = 0; m_blink = 0;
  endtask

  task automatic model_step();
    int old, ff, h;
    bit chg;
    if (!nCR) begin
      model_reset();
      return;
    end
    m_cyc++;
    old = m_st;
    ff = 0;
    if (m_pend_m) m_st = (m_st + 1) % 4;
    else if (m_st != 0 && m_idle >= TO - 1) m_st = 0;
    chg = (m_st != old);
    if (m_pend_a && !m_pend_m && old != 0) begin
      ff = old;
      m_hold_start = m_cyc;
      m_rpt_on = AR && (old == 1 || old == 2);
    end else if (m_rpt_on && m_samp_a && !m_pend_m && !chg) begin
      h = m_cyc - m_hold_start;
      if (h == HOLD || (h > HOLD && (h - HOLD) % RPT == 0)) ff = old;
    end else begin
      m_rpt_on = 0;
    end
    if (chg || m_pend_m || m_pend_a || m_samp_a || m_st == 0) m_idle = 0;
    else if (m_idle < TO - 1) m_idle++;
    if (chg) m_since = 0;
    else m_since++;
    m_fire  = ff;
    m_blink = (m_st != 0) && ((m_since / BL) % 2 == 1) && (ff == 0);
    m_pend_m = btn_mode && !m_prev_m && m_arm_m;
    m_pend_a = btn_adj && !m_prev_a && m_arm_a;
    if (!btn_mode) m_arm_m = 1;
    if (!btn_adj) m_arm_a = 1;
    m_prev_m = btn_mode;
    m_prev_a = btn_adj;
    m_samp_a = btn_adj;
  endtask

  function automatic logic [6:0] exp_vec();
    logic [1:0] s;
    s = 2'(m_st);
    return {s, m_st == 0, m_fire == 1, m_fire == 2, m_fire == 3, m_blink};
  endfunction

  task automatic drive_tick(input logic m, input logic a);
    btn_mode = m;
    btn_adj  = a;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    nCR = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (dut_vec !== 7'b0010000) $display("FAIL reset_vals: got %b want %b", dut_vec, 7'b0010000);
    else n_pass++;
    nCR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_tick(1'b0, 1'b0);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL reset_idle: got %b want %b t=%0t", dut_vec, exp_vec(), $time);
      else n_pass++;
    end
  endtask

  task automatic test_mode_cycle();
    int exp_sel[4];
    int prev;
    exp_sel = '{1, 2, 3, 0};
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      drive_tick(1'b1, 1'b0);
      n_chk++;
      if (sel !== 2'(prev)) $display("FAIL mode_early: sel got %0d want %0d", sel, prev);
      else n_pass++;
      drive_tick(1'b0, 1'b0);
      n_chk++;
      if (sel !== 2'(exp_sel[i]) || run_en !== (exp_sel[i] == 0))
        $display("FAIL mode_step%0d: sel/run_en got %0d/%b want %0d/%b", i, sel, run_en, exp_sel[i], exp_sel[i] == 0);
      else n_pass++;
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL mode_model: got %b want %b t=%0t", dut_vec, exp_vec(), $time);
      else n_pass++;
      prev = exp_sel[i];
    end
  endtask

  task automatic test_adj_min();
    int n_min, n_hr, first;
    for (int i = 0; i < 2; i++) begin
      drive_tick(1'b1, 1'b0);
      drive_tick(1'b0, 1'b0);
    end
    n_min = 0; n_hr = 0; first = -1;
    for (int i = 0; i < 8; i++) begin
      drive_tick(1'b0, i < 5);
      if (inc_min === 1'b1) begin
        n_min++;
        if (first < 0) first = i;
      end
      if (inc_hr === 1'b1) n_hr++;
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL adj_min_model: got %b want %b t=%0t", dut_vec, exp_vec(), $time);
      else n_pass++;
    end
    n_chk++;
    if (n_min != 1 || first != 1 || n_hr != 0)
      $display("FAIL adj_min_pulse: count/offset/hr got %0d/%0d/%0d want 1/1/0", n_min, first, n_hr);
    else n_pass++;
  endtask

  task automatic test_hold_hr();
    int offs[$];
    int exp_offs[$];
    for (int i = 0; i < 3; i++) begin
      drive_tick(1'b1, 1'b0);
      drive_tick(1'b0, 1'b0);
    end
    for (int i = 0; i < 1010; i++) begin
      drive_tick(1'b0, i < 1000);
      if (inc_hr === 1'b1) offs.push_back(i);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL hold_model: got %b want %b t=%0t", dut_vec, exp_vec(), $time);
      else n_pass++;
    end
`ifdef TIME_SET_AUTO_REPEAT_EN
    exp_offs = '{1, 501, 701, 901};
`else
    exp_offs = '{1};
`endif
    n_chk++;
    if (offs.size() != exp_offs.size())
      $display("FAIL hold_count: got %0d pulses want %0d", offs.size(), exp_offs.size());
    else n_pass++;
    foreach (exp_offs[k]) begin
      n_chk++;
      if (k >= offs.size()) $display("FAIL hold_offset%0d: got none want %0d", k, exp_offs[k]);
      else if (offs[k] != exp_offs[k]) $display("FAIL hold_offset%0d: got %0d want %0d", k, offs[k], exp_offs[k]);
      else n_pass++;
    end
  endtask

  task automatic test_coincident();
    int n_hr;
    n_hr = 0;
    for (int i = 0; i < 5; i++) begin
      drive_tick(i == 0, i == 0);
      if (inc_hr === 1'b1) n_hr++;
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL coinc_model: got %b want %b t=%0t", dut_vec, exp_vec(), $time);
      else n_pass++;
    end
    n_chk++;
    if (sel !== 2'd2 || n_hr != 0) $display("FAIL coinc: sel/inc_hr got %0d/%0d want 2/0", sel, n_hr);
    else n_pass++;
  endtask

  task automatic test_timeout();
    drive_tick(1'b1, 1'b0);
    drive_tick(1'b0, 1'b0);
    n_chk++;
    if (sel !== 2'd3) $display("FAIL to_entry: sel got %0d want 3", sel);
    else n_pass++;
    for (int t = 1; t <= TO; t++) begin
      drive_tick(1'b0, 1'b0);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL to_model: got %b want %b t=%0t", dut_vec, exp_vec(), $time);
      else n_pass++;
      if (t == BL - 1 || t == BL) begin
        n_chk++;
        if (blink !== (t == BL)) $display("FAIL blink_edge: t=%0d got %b want %b", t, blink, t == BL);
        else n_pass++;
      end
      if (t == TO - 1) begin
        n_chk++;
        if (sel !== 2'd3) $display("FAIL to_early: sel got %0d want 3", sel);
        else n_pass++;
      end
    end
    n_chk++;
    if (sel !== 2'd0 || run_en !== 1'b1 || blink !== 1'b0)
      $display("FAIL to_exit: sel/run_en/blink got %0d/%b/%b want 0/1/0", sel, run_en, blink);
    else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    int n_pulse;
    for (int i = 0; i < 2; i++) begin
      drive_tick(1'b1, 1'b0);
      drive_tick(1'b0, 1'b0);
    end
    for (int i = 0; i < 50; i++) drive_tick(1'b0, 1'b1);
    nCR = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (dut_vec !== 7'b0010000) $display("FAIL async_reset: got %b want %b", dut_vec, 7'b0010000);
    else n_pass++;
    drive_tick(1'b0, 1'b1);
    drive_tick(1'b0, 1'b1);
    nCR = 1'b1;
    n_pulse = 0;
    for (int i = 0; i < 722; i++) begin
      drive_tick(i == 20, 1'b1);
      n_pulse += int'(inc_hr) + int'(inc_min) + int'(clr_sec);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL held_model: got %b want %b t=%0t", dut_vec, exp_vec(), $time);
      else n_pass++;
    end
    n_chk++;
    if (sel !== 2'd1 || n_pulse != 0) $display("FAIL held_release: sel/pulses got %0d/%0d want 1/0", sel, n_pulse);
    else n_pass++;
    n_pulse = 0;
    for (int i = 0; i < 6; i++) begin
      drive_tick(1'b0, i == 2);
      if (inc_hr === 1'b1) n_pulse++;
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL repress_model: got %b want %b t=%0t", dut_vec, exp_vec(), $time);
      else n_pass++;
    end
    n_chk++;
    if (n_pulse != 1) $display("FAIL repress_pulse: got %0d want 1", n_pulse);
    else n_pass++;
  endtask

  task automatic test_random();
    logic m, a;
    m = 1'b0;
    a = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) m = ~m;
      if ($urandom_range(0, 39) == 0) a = ~a;
      if (i == 2000) begin
        nCR = 1'b0;
        model_reset();
      end
      if (i == 2003) nCR = 1'b1;
      drive_tick(m, a);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL random_model: i=%0d got %b want %b", i, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    m_cyc = 0;
    test_reset();
    test_mode_cycle();
    test_adj_min();
    test_hold_hr();
    test_coincident();
    test_timeout();
    test_reset_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
